pauli_rom_sequencer: RTL and testbench

- Sequences reads of the Pauli-string block ROM and streams one ROM word per beat to the downstream measurement/tomography datapath over a valid/ready interface.
- Issues ROM reads for a programmed run: base address plus entry count.
- Absorbs the ROM's fixed read latency with a credit-limited skid FIFO, so downstream backpressure never loses data.
- Sits between the run controller (start/abort) and the brom_controller instance (en/addr/dout).

---
 rtl/pauli_rom_sequencer.sv | 273 +++++++++++++++++++++++++++
 tb/tb_pauli_rom_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pauli_rom_sequencer.sv
// ---------------------------------------------------------------------------
// pauli_rom_sequencer
//
// Reads a run of encoded Pauli strings out of the block ROM and streams them,
// one word per beat, to the measurement/tomography datapath over valid/ready.
// A run is a base address plus an entry count. Reads are issued only while
// there is guaranteed room for their data. That room is the in-flight tag
// count plus the skid FIFO occupancy, and it must stay below FIFO_DEPTH.
// Because of this, downstream backpressure can never drop a returning word.
//
// Ports
//   clk        posedge clock
//   rst_n      synchronous active-low reset
//   start      one-cycle run request (IDLE only, ignored together with abort)
//   abort      cancel the current run, flush FIFO and in-flight tags
//   base_addr  first ROM address of the run
//   count      number of strings in the run (0 = empty run)
//   busy       run in progress (RUN/DRAIN)
//   done       one-cycle pulse on normal completion
//   rom_en     ROM read enable
//   rom_addr   ROM read address (wraps modulo 2^ADDR_W)
//   rom_dout   ROM read data, valid ROM_LAT cycles after rom_en
//   m_data     streamed Pauli string
//   m_valid    m_data valid
//   m_ready    downstream accept
//   m_last     final beat of the run
//   m_index    0-based beat number within the run
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; run parameters captured on accepted start
// RUN    | issuing ROM reads while entries remain and credit allows
// DRAIN  | all reads issued; waiting for in-flight data and FIFO to empty
// FIN    | one-cycle done pulse, then back to IDLE
// ---------------------------------------------------------------------------
module pauli_rom_sequencer #(
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 64,
  parameter int ROM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_dout,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic [ADDR_W:0]   m_index
);

  localparam int FIFO_DEPTH = ROM_LAT + 2;
  localparam int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W      = CNT_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   issued_q, issued_d;
  logic [ADDR_W:0]   out_idx_q, out_idx_d;
  logic [ROM_LAT-1:0] tag_q, tag_d;

  logic [DATA_W-1:0] fifo_mem [0:FIFO_DEPTH-1];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;

  logic [CNT_W-1:0]  inflight;
  logic [OCC_W-1:0]  occupancy;
  logic              credit_ok;
  logic              accept_start;
  logic              flush;
  logic              push;
  logic              pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FIFO_DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  // Reads currently travelling through the ROM pipeline.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < ROM_LAT; i++) begin
      inflight = inflight + CNT_W'(tag_q[i]);
    end
  end

  // Credit uses only registered occupancy; a pop in this cycle does not
  // free a slot until the next one, which keeps the bound simple and safe.
  assign occupancy = OCC_W'(inflight) + OCC_W'(fifo_cnt_q);
  assign credit_ok = (occupancy < OCC_W'(FIFO_DEPTH));

  assign accept_start = (state_q == S_IDLE) && start && !abort;
  assign flush        = (state_q != S_IDLE) && abort;

  assign rom_en   = (state_q == S_RUN) && (issued_q < count_q) && credit_ok;
  assign rom_addr = base_q + issued_q[ADDR_W-1:0];

  // The oldest tag matures exactly when its rom_dout is on the bus.
  assign push = tag_q[ROM_LAT-1] && !flush;

  assign m_valid = (fifo_cnt_q != '0);
  assign pop     = m_valid && m_ready && !flush;
  assign m_data  = m_valid ? fifo_mem[rd_ptr_q] : '0;
  assign m_index = out_idx_q;
  assign m_last  = m_valid && (out_idx_q == (count_q - (ADDR_W+1)'(1)));

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_start) begin
          state_d = (count == '0) ? S_FIN : S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (abort) begin
          state_d = S_IDLE;
        end else if (issued_q == count_q) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (abort) begin
          state_d = S_IDLE;
        end else if ((fifo_cnt_q == '0) && (inflight == '0)) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Run counters and in-flight tags
  // -------------------------------------------------------------------------
  always_comb begin
    base_d    = base_q;
    count_d   = count_q;
    issued_d  = issued_q;
    out_idx_d = out_idx_q;
    tag_d     = '0;

    if (accept_start) begin
      base_d    = base_addr;
      count_d   = count;
      issued_d  = '0;
      out_idx_d = '0;
    end else if (flush) begin
      base_d    = '0;
      count_d   = '0;
      issued_d  = '0;
      out_idx_d = '0;
    end else begin
      if (rom_en) begin
        issued_d = issued_q + (ADDR_W+1)'(1);
      end
      if (pop) begin
        out_idx_d = out_idx_q + (ADDR_W+1)'(1);
      end
    end

    // Abort clears the pipeline so late rom_dout never reaches the FIFO.
    if (!flush) begin
      tag_d[0] = rom_en;
      for (int i = 1; i < ROM_LAT; i++) begin
        tag_d[i] = tag_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base_q    <= '0;
      count_q   <= '0;
      issued_q  <= '0;
      out_idx_q <= '0;
      tag_q     <= '0;
    end else begin
      base_q    <= base_d;
      count_q   <= count_d;
      issued_q  <= issued_d;
      out_idx_q <= out_idx_d;
      tag_q     <= tag_d;
    end
  end

  // -------------------------------------------------------------------------
  // Skid FIFO
  // -------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fifo_cnt_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
        2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
        default: fifo_cnt_d = fifo_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // Storage needs no reset; m_data is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      fifo_mem[wr_ptr_q] <= rom_dout;
    end
  end

endmodule

// File: tb/tb_pauli_rom_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pauli_rom_sequencer
//
// Directed bench for pauli_rom_sequencer with ROM_LAT=1. A behavioural ROM
// returns a known word per address one cycle after rom_en. A negedge monitor
// records reads, beats, done pulses, per-cycle busy/valid, handshake
// stability and FIFO+in-flight occupancy relative to the start cycle (t0).
// ---------------------------------------------------------------------------
module tb_pauli_rom_sequencer;

  localparam int ADDR_W  = 6;
  localparam int DATA_W  = 64;
  localparam int ROM_LAT = 1;
  localparam int DEPTH   = ROM_LAT + 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   count;
  logic              busy;
  logic              done;
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_dout = '0;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;
  logic [ADDR_W:0]   m_index;

  pauli_rom_sequencer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .ROM_LAT(ROM_LAT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .base_addr(base_addr),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .rom_en   (rom_en),
    .rom_addr (rom_addr),
    .rom_dout (rom_dout),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_last   (m_last),
    .m_index  (m_index)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] rom_word(input logic [5:0] a);
    return {16'hBEEF, 2'b00, a, 16'h1234, 10'd0, a, 8'h5A};
  endfunction

  always @(posedge clk) begin
    if (rom_en) rom_dout <= rom_word(rom_addr);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // monitor state
  int          t0 = 1000000;
  int          rom_cyc_q[$];
  logic [5:0]  rom_addr_q[$];
  logic [63:0] beat_data_q[$];
  int          beat_idx_q[$];
  logic        beat_last_q[$];
  int          beat_cyc_q[$];
  int          done_cnt, done_cyc, stab_err, max_occ, valid_cnt;
  logic        valid_at[64];
  logic        busy_at[64];
  logic        stall_prev = 1'b0;
  logic        abort_prev = 1'b0;
  logic [63:0] prev_data;
  logic [6:0]  prev_idx;
  logic        prev_last;

  always @(negedge clk) begin
    int rel;
    int occ;
    rel = cyc - t0;
    if (rst_n === 1'b1) begin
      if (rel >= 0 && rel < 64) begin
        valid_at[rel] = m_valid;
        busy_at[rel]  = busy;
      end
      if (rom_en) begin
        rom_addr_q.push_back(rom_addr);
        rom_cyc_q.push_back(rel);
      end
      if (m_valid) valid_cnt++;
      if (m_valid && m_ready) begin
        beat_data_q.push_back(m_data);
        beat_idx_q.push_back(int'(m_index));
        beat_last_q.push_back(m_last);
        beat_cyc_q.push_back(rel);
      end
      if (done) begin
        done_cnt++;
        done_cyc = rel;
      end
      if (stall_prev && !abort_prev) begin
        if (!m_valid || m_data !== prev_data || m_index !== prev_idx || m_last !== prev_last)
          stab_err++;
      end
      occ = int'(dut.inflight) + int'(dut.fifo_cnt_q);
      if (occ > max_occ) max_occ = occ;
    end
    stall_prev = m_valid && !m_ready;
    abort_prev = abort;
    prev_data  = m_data;
    prev_idx   = m_index;
    prev_last  = m_last;
  end

  function automatic logic ready_pat(input int mode, input int k);
    case (mode)
      1:       return ((k % 4) == 0) || ((k % 4) == 3);
      2:       return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  // Start is driven in relative cycle 0; optional second start / abort cycles.
  task automatic run_seq(input logic [5:0] b, input logic [6:0] n, input int mode,
                         input int restart_at, input int abort_at, input int ncyc);
    rom_cyc_q.delete(); rom_addr_q.delete();
    beat_data_q.delete(); beat_idx_q.delete(); beat_last_q.delete(); beat_cyc_q.delete();
    done_cnt = 0; done_cyc = -1; stab_err = 0; max_occ = 0; valid_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      valid_at[i] = 1'bx;
      busy_at[i]  = 1'bx;
    end
    @(posedge clk); #1;
    t0        = cyc;
    base_addr = b;
    count     = n;
    start     = 1'b1;
    abort     = (abort_at == 0);
    m_ready   = ready_pat(mode, 0);
    for (int k = 1; k < ncyc; k++) begin
      @(posedge clk); #1;
      start = (k == restart_at);
      if (k == restart_at) begin
        base_addr = 6'd0;
        count     = 7'd2;
      end
      abort   = (k == abort_at);
      m_ready = ready_pat(mode, k);
    end
    start   = 1'b0;
    abort   = 1'b0;
    m_ready = 1'b1;
  endtask

  task automatic check_stream(input string tag, input logic [5:0] b, input int n);
    chk({tag, "_beats"}, beat_data_q.size(), n);
    for (int i = 0; i < n && i < beat_data_q.size(); i++) begin
      logic [5:0] a;
      a = b + 6'(i);
      chk({tag, "_data"}, beat_data_q[i], rom_word(a));
      chk({tag, "_index"}, beat_idx_q[i], i);
      chk({tag, "_last"}, beat_last_q[i], (i == n - 1));
    end
    chk({tag, "_reads"}, rom_addr_q.size(), n);
    for (int i = 0; i < n && i < rom_addr_q.size(); i++) begin
      logic [5:0] a;
      a = b + 6'(i);
      chk({tag, "_addr"}, rom_addr_q[i], a);
    end
    chk({tag, "_done_cnt"}, done_cnt, 1);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    base_addr = '0;
    count     = '0;
    m_ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",     busy,     0);
    chk("rst_done",     done,     0);
    chk("rst_rom_en",   rom_en,   0);
    chk("rst_m_valid",  m_valid,  0);
    chk("rst_m_last",   m_last,   0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_m_data",   m_data,   0);
    chk("rst_m_index",  m_index,  0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // basic run: reads cycles 1-4, beats 3-6, done at 8
    run_seq(6'd0, 7'd4, 0, -1, -1, 14);
    check_stream("basic", 6'd0, 4);
    for (int i = 0; i < 4 && i < rom_cyc_q.size(); i++)
      chk("basic_rom_cyc", rom_cyc_q[i], 1 + i);
    for (int i = 0; i < 4 && i < beat_cyc_q.size(); i++)
      chk("basic_beat_cyc", beat_cyc_q[i], 3 + i);
    chk("basic_done_cyc", done_cyc, 8);
    chk("basic_busy_c0", busy_at[0], 0);
    chk("basic_busy_c1", busy_at[1], 1);
    chk("basic_busy_fin", busy_at[8], 0);

    // address wrap
    run_seq(6'd62, 7'd4, 0, -1, -1, 14);
    check_stream("wrap", 6'd62, 4);

    // backpressure
    run_seq(6'd20, 7'd8, 1, -1, -1, 50);
    check_stream("bp", 6'd20, 8);
    chk("bp_stable_err", stab_err, 0);
    chk("bp_occ_le_depth", (max_occ <= DEPTH), 1);

    // zero count
    run_seq(6'd7, 7'd0, 0, -1, -1, 8);
    chk("zero_reads", rom_addr_q.size(), 0);
    chk("zero_valid", valid_cnt, 0);
    chk("zero_done_cyc", done_cyc, 1);
    chk("zero_done_cnt", done_cnt, 1);

    // abort mid-run with downstream stalled
    run_seq(6'd0, 7'd16, 2, -1, 6, 14);
    chk("abort_valid_c6", valid_at[6], 1);
    chk("abort_busy_c6",  busy_at[6],  1);
    chk("abort_valid_c7", valid_at[7], 0);
    chk("abort_busy_c7",  busy_at[7],  0);
    chk("abort_done_cnt", done_cnt, 0);
    chk("abort_beats", beat_data_q.size(), 0);
    chk("abort_occ_le_depth", (max_occ <= DEPTH), 1);
    run_seq(6'd5, 7'd2, 0, -1, -1, 12);
    check_stream("post_abort", 6'd5, 2);

    // second start during RUN is ignored
    run_seq(6'd10, 7'd5, 0, 3, -1, 16);
    check_stream("restart", 6'd10, 5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
